// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for asynchronous request levels: each request is synchronized,
// then one requester at a time is granted until done, request drop or hold timeout.
module sync_req_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_MAX    = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_nsyn,
  input  logic                 done,
  output logic [N-1:0]         req_syn,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(HOLD_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  logic [N-1:0]  r_sync [SYNC_STAGES];
  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic          r_gnt_valid;
  logic [IW-1:0] r_gnt_id;
  logic          r_timeout;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_ptr;

  state_t        w_state_nxt;
  logic [N-1:0]  w_gnt_nxt;
  logic          w_gnt_valid_nxt;
  logic [IW-1:0] w_gnt_id_nxt;
  logic          w_timeout_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [IW-1:0] w_ptr_nxt;

  logic          w_any;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic          w_hit;
  logic [N-1:0]  w_onehot;
  logic          w_cnt_max;

  // Per-bit synchronizer chains; req_nsyn touches only stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= {N{1'b0}};
      end
    end else begin
      r_sync[0] <= req_nsyn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign req_syn = r_sync[SYNC_STAGES-1];

  // Round-robin search from ptr+1 upward; descending loop lets the nearest hit win.
  always_comb begin
    w_any = 1'b0;
    w_win = {IW{1'b0}};
    w_idx = {IW{1'b0}};
    w_hit = 1'b0;
    for (int i = N; i >= 1; i--) begin
      w_idx = IW'((int'(r_ptr) + i) % N);
      w_hit = req_syn[w_idx];
      w_any = w_any | w_hit;
      w_win = w_hit ? w_idx : w_win;
    end
  end

  assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_win;
  assign w_cnt_max = (r_cnt == CW'(HOLD_MAX - 1));

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_id_nxt    = r_gnt_id;
    w_timeout_nxt   = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_ptr_nxt       = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt     = S_GRANT;
          w_gnt_nxt       = w_onehot;
          w_gnt_valid_nxt = 1'b1;
          w_gnt_id_nxt    = w_win;
          w_cnt_nxt       = {CW{1'b0}};
        end else begin
          w_gnt_nxt       = {N{1'b0}};
          w_gnt_valid_nxt = 1'b0;
        end
      end
      S_GRANT: begin
        // done has priority over the hold timeout.
        if (done || !req_syn[r_gnt_id]) begin
          w_state_nxt     = S_RELEASE;
          w_gnt_nxt       = {N{1'b0}};
          w_gnt_valid_nxt = 1'b0;
        end else if (w_cnt_max) begin
          w_state_nxt     = S_RELEASE;
          w_gnt_nxt       = {N{1'b0}};
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RELEASE: begin
        w_state_nxt     = S_IDLE;
        w_gnt_nxt       = {N{1'b0}};
        w_gnt_valid_nxt = 1'b0;
        w_ptr_nxt       = r_gnt_id;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_gnt_nxt       = {N{1'b0}};
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; ptr resets to N-1 so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= {N{1'b0}};
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= {IW{1'b0}};
      r_timeout   <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_ptr       <= IW'(N - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Directed bench for sync_req_arbiter: sync latency, round-robin order,
// hold timeout, done priority, async reset mid-grant and request drop.
module tb_sync_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_nsyn;
  logic       done;
  logic [3:0] req_syn;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  int n_checks;
  int n_errors;

  sync_req_arbiter #(.N(4), .SYNC_STAGES(3), .HOLD_MAX(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_nsyn  (req_nsyn),
    .done      (done),
    .req_syn   (req_syn),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_nsyn = 4'b0000;
    done     = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    req_nsyn = 4'b0000;
    done     = 1'b0;
    #1;
    check_val("rst_gnt",     32'(gnt),       32'h0);
    check_val("rst_valid",   32'(gnt_valid), 32'h0);
    check_val("rst_id",      32'(gnt_id),    32'h0);
    check_val("rst_timeout", 32'(timeout),   32'h0);
    check_val("rst_reqsyn",  32'(req_syn),   32'h0);
    step();

    // Sync latency: req_syn after 3 edges, grant on the 4th.
    rst_n    = 1'b1;
    req_nsyn = 4'b0100;
    step();
    check_val("sync_e1", 32'(req_syn), 32'h0);
    step();
    check_val("sync_e2", 32'(req_syn), 32'h0);
    step();
    check_val("sync_e3", 32'(req_syn), 32'h4);
    check_val("gnt_e3",  32'(gnt),     32'h0);
    step();
    check_val("gnt_e4",   32'(gnt),       32'h4);
    check_val("id_e4",    32'(gnt_id),    32'h2);
    check_val("valid_e4", 32'(gnt_valid), 32'h1);
    done = 1'b1;
    step();
    check_val("rel_gnt",   32'(gnt),       32'h0);
    check_val("rel_valid", 32'(gnt_valid), 32'h0);
    check_val("rel_to",    32'(timeout),   32'h0);
    check_val("rel_id",    32'(gnt_id),    32'h2);
    done = 1'b0;
    step();
    check_val("idle_gnt", 32'(gnt), 32'h0);

    // Round-robin over all four requesters.
    do_reset();
    req_nsyn = 4'b1111;
    steps(3);
    check_val("rr_pre", 32'(gnt), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_val($sformatf("rr_gnt%0d", k), 32'(gnt),    32'h1 << exp_order[k]);
      check_val($sformatf("rr_id%0d", k),  32'(gnt_id), 32'(exp_order[k]));
      done = 1'b1;
      step();
      check_val($sformatf("rr_gap1_%0d", k), 32'(gnt), 32'h0);
      done = 1'b0;
      step();
      check_val($sformatf("rr_gap2_%0d", k), 32'(gnt), 32'h0);
    end

    // Hold timeout: 15 grant cycles, then one timeout pulse, then regrant.
    do_reset();
    req_nsyn = 4'b0001;
    steps(3);
    for (int c = 0; c < 15; c++) begin
      step();
      check_val($sformatf("hold_gnt%0d", c), 32'(gnt),     32'h1);
      check_val($sformatf("hold_to%0d", c),  32'(timeout), 32'h0);
    end
    step();
    check_val("to_gnt",   32'(gnt),     32'h0);
    check_val("to_pulse", 32'(timeout), 32'h1);
    step();
    check_val("to_gap_gnt", 32'(gnt),     32'h0);
    check_val("to_clear",   32'(timeout), 32'h0);
    step();
    check_val("regrant", 32'(gnt), 32'h1);

    // done in the same cycle as the timeout condition wins.
    steps(14);
    check_val("dt_held", 32'(gnt), 32'h1);
    done = 1'b1;
    step();
    check_val("dt_gnt", 32'(gnt),     32'h0);
    check_val("dt_to",  32'(timeout), 32'h0);
    done = 1'b0;
    step();
    check_val("dt_to2", 32'(timeout), 32'h0);

    // Asynchronous reset between edges during a grant.
    do_reset();
    req_nsyn = 4'b1111;
    steps(4);
    check_val("ar_gnt0", 32'(gnt), 32'h1);
    done = 1'b1;
    step();
    done = 1'b0;
    steps(2);
    check_val("ar_gnt1", 32'(gnt), 32'h2);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("ar_gnt",    32'(gnt),       32'h0);
    check_val("ar_valid",  32'(gnt_valid), 32'h0);
    check_val("ar_reqsyn", 32'(req_syn),   32'h0);
    step();
    rst_n = 1'b1;
    steps(3);
    check_val("ar_nogrant", 32'(gnt),     32'h0);
    check_val("ar_sync",    32'(req_syn), 32'hF);
    step();
    check_val("ar_restart", 32'(gnt),    32'h1);
    check_val("ar_id",      32'(gnt_id), 32'h0);

    // Request drop mid-grant releases 3+1 edges later without timeout.
    do_reset();
    req_nsyn = 4'b0010;
    steps(4);
    check_val("drop_gnt", 32'(gnt), 32'h2);
    steps(2);
    req_nsyn = 4'b0000;
    steps(3);
    check_val("drop_hold",   32'(gnt),     32'h2);
    check_val("drop_reqsyn", 32'(req_syn), 32'h0);
    step();
    check_val("drop_rel", 32'(gnt),     32'h0);
    check_val("drop_to",  32'(timeout), 32'h0);
    step();
    check_val("drop_idle", 32'(gnt),     32'h0);
    check_val("drop_to2",  32'(timeout), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_req_arbiter.md
SYNC_REQ_ARBITER -- requirements
Module: sync_req_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 3, giving the synchronizer flop depth per request (>=2).
REQ-003 The block SHALL have parameter HOLD_MAX, default 15, giving the maximum grant length in cycles before a forced release (>=2).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all flops rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_nsyn, input, N bits: asynchronous request levels, one per requester.
REQ-007 The block SHALL have port done, input, 1 bit: synchronous, current grantee finished.
REQ-008 The block SHALL have port req_syn, output, N bits: synchronized requests (last sync stage).
REQ-009 The block SHALL have port gnt, output, N bits: registered one-hot grant.
REQ-010 The block SHALL have port gnt_valid, output, 1 bit: high iff gnt is nonzero.
REQ-011 The block SHALL have port gnt_id, output, clog2(N) bits: index of the current or last grantee.
REQ-012 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-013 Each req_nsyn bit SHALL pass through its own SYNC_STAGES-deep flop chain; req_syn SHALL follow a stable req_nsyn change after exactly SYNC_STAGES rising edges.
REQ-014 Only req_syn SHALL feed arbitration logic; req_nsyn SHALL drive nothing but the first sync stage.
REQ-015 The FSM SHALL have states IDLE, GRANT and RELEASE.
REQ-016 In IDLE with req_syn nonzero, the FSM SHALL pick the first set bit searching upward from (ptr+1) mod N, wrapping; at the next edge: gnt one-hot, gnt_id = winner, gnt_valid = 1, hold counter = 0, state GRANT.
REQ-017 In IDLE with req_syn == 0, the FSM SHALL stay in IDLE with gnt = 0.
REQ-018 In GRANT, the hold counter SHALL increment each cycle, saturating at HOLD_MAX-1.
REQ-019 In GRANT, if done = 1 or req_syn[gnt_id] = 0, the FSM SHALL move to RELEASE at the next edge without pulsing timeout.
REQ-020 In GRANT with done = 0, req_syn[gnt_id] = 1 and counter = HOLD_MAX-1, the FSM SHALL move to RELEASE and assert timeout for exactly that one following cycle.
REQ-021 If done and the timeout condition occur in the same cycle, done SHALL win and timeout SHALL stay 0.
REQ-022 In RELEASE, gnt and gnt_valid SHALL be 0 for exactly one cycle, ptr SHALL be loaded with gnt_id, gnt_id SHALL hold, and the next state SHALL be IDLE.
REQ-023 Grants SHALL therefore be separated by at least 2 cycles with gnt = 0 (RELEASE, IDLE); gnt SHALL never have more than one bit set.
REQ-024 A requester still requesting after release (including after timeout) SHALL remain eligible but SHALL rank last behind all other requesters under round-robin.
REQ-025 done SHALL be ignored in IDLE and RELEASE.

Reset
REQ-026 On rst_n = 0, the block SHALL immediately, without a clock, clear all sync flops, set state IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0, timeout = 0, counter = 0 and ptr = N-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-grant SHALL drop gnt in the same cycle.
REQ-028 After rst_n deassertion, no grant SHALL appear earlier than SYNC_STAGES+1 edges after any request.

Verification
REQ-029 Bench: reset, then req_nsyn = 0100 held -> req_syn[2] rises after 3 edges; gnt = 0100, gnt_id = 2 on the 4th edge.
REQ-030 Bench: req_nsyn = 1111 held, done pulsed 1 cycle after each grant -> grant order 0,1,2,3,0 with 2 zero-gnt cycles between grants.
REQ-031 Bench: req 0001 held, done never asserted -> gnt[0] high 15 cycles, then timeout = 1 for 1 cycle, gnt = 0, and gnt[0] regranted after the gap.
REQ-032 Bench: done = 1 in the cycle counter = 14 -> RELEASE entered with timeout staying 0.
REQ-033 Bench: rst_n pulled low during GRANT between clock edges -> gnt, gnt_valid and req_syn are 0 immediately; after release, grant order restarts at requester 0.
REQ-034 Bench: requester 1 drops req_nsyn mid-grant with done = 0 -> gnt drops 3+1 edges later through RELEASE, timeout stays 0.
